// File: rtl/hard_and_sync_filt_pkg.sv
// rtl/hard_and_sync_filt_pkg.sv - shared state type and constants for hard_and_sync_filt
package hard_and_sync_filt_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    QUAL = 2'd1,
    ON   = 2'd2
  } filt_state_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/hard_sync_cell.sv
// rtl/hard_sync_cell.sv - 1-bit multi-flop synchroniser, the per-target library-dependent cell
module hard_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  // shift the async input through the flop chain; reset clears every stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/hard_and_sync_filt.sv
// rtl/hard_and_sync_filt.sv - multi-channel synchronised AND with slow-on/fast-off filter; HARD_AND_SYNC_FILT_DROP_CNT_EN adds fall counters
module hard_and_sync_filt
  import hard_and_sync_filt_pkg::*;
#(
  parameter int NB_CH       = 1,
  parameter int NB_IN       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NB_CH*NB_IN-1:0]        i_in,
  input  logic [NB_CH-1:0]              i_frc_off,
`ifdef HARD_AND_SYNC_FILT_DROP_CNT_EN
  input  logic                          i_drop_clr,
  output logic [NB_CH*DROP_CNT_W-1:0]   o_drop_cnt,
`endif
  output logic [NB_CH-1:0]              o_and,
  output logic [NB_CH-1:0]              o_rise,
  output logic [NB_CH-1:0]              o_fall
);

  localparam int              CNT_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // with a one-cycle filter OFF goes straight to ON and the count is never needed
  localparam logic [CNT_W-1:0] CNT_SEED = (FILT_CYCLES == 1) ? '0 : CNT_ONE;
  localparam bit              FILT_ONE = (FILT_CYCLES == 1);

  logic [NB_CH*NB_IN-1:0] in_s;

  for (genvar b = 0; b < NB_CH*NB_IN; b++) begin : g_sync
    hard_sync_cell #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_in[b]),
      .o_q   (in_s[b])
    );
  end

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    filt_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             and_s;
    logic             stop;
    logic             on_nxt;
    logic             and_q;
    logic             rise_q;
    logic             fall_q;

    assign and_s = &in_s[c*NB_IN +: NB_IN];
    // force-off dominates the synchronised AND in every state
    assign stop  = i_frc_off[c] | ~and_s;
    assign on_nxt = ~stop & ((state == ON) |
                             ((state == QUAL) & (cnt == CNT_LAST)) |
                             ((state == OFF) & FILT_ONE));

    // filter FSM with the output and edge pulses registered alongside the state
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state  <= OFF;
        cnt    <= '0;
        and_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        case (state)
          OFF: begin
            if (!stop) begin
              state <= FILT_ONE ? ON : QUAL;
              cnt   <= CNT_SEED;
            end else begin
              cnt   <= '0;
            end
          end
          QUAL: begin
            if (stop) begin
              state <= OFF;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= ON;
            end else begin
              cnt   <= cnt + CNT_ONE;
            end
          end
          ON: begin
            if (stop) begin
              state <= OFF;
              cnt   <= '0;
            end
          end
          default: begin
            state <= OFF;
            cnt   <= '0;
          end
        endcase
        and_q  <= on_nxt;
        rise_q <= on_nxt & ~and_q;
        fall_q <= ~on_nxt & and_q;
      end
    end

    assign o_and[c]  = and_q;
    assign o_rise[c] = rise_q;
    assign o_fall[c] = fall_q;

`ifdef HARD_AND_SYNC_FILT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q;

    // saturating count of fall events; a coincident clear discards the event
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        drop_q <= '0;
      end else if (i_drop_clr) begin
        drop_q <= '0;
      end else if (fall_q && (drop_q != {DROP_CNT_W{1'b1}})) begin
        drop_q <= drop_q + DROP_CNT_W'(1);
      end
    end

    assign o_drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = drop_q;
`endif
  end

endmodule
